// File: rtl/risc_pkg.sv
// Shared encodings for the five-stage RISC datapath: opcodes, instruction field positions, ALU ops.
package risc_pkg;

  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 28;
  localparam int unsigned RdMsb  = 27;
  localparam int unsigned RdLsb  = 23;
  localparam int unsigned Rs1Msb = 22;
  localparam int unsigned Rs1Lsb = 18;
  localparam int unsigned Rs2Msb = 17;
  localparam int unsigned Rs2Lsb = 13;
  localparam int unsigned ImmMsb = 12;
  localparam int unsigned ImmW   = 13;

  localparam logic [3:0] OpcNop  = 4'd0;
  localparam logic [3:0] OpcAdd  = 4'd1;
  localparam logic [3:0] OpcSub  = 4'd2;
  localparam logic [3:0] OpcAnd  = 4'd3;
  localparam logic [3:0] OpcOr   = 4'd4;
  localparam logic [3:0] OpcXor  = 4'd5;
  localparam logic [3:0] OpcSll  = 4'd6;
  localparam logic [3:0] OpcSrl  = 4'd7;
  localparam logic [3:0] OpcAddi = 4'd8;
  localparam logic [3:0] OpcLw   = 4'd9;
  localparam logic [3:0] OpcSw   = 4'd10;

  typedef enum logic [2:0] {
    AluZero,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl
  } alu_op_e;

  // ADDI, LW and SW all compute rs1 + imm as their ALU result.
  function automatic alu_op_e alu_decode(input logic [3:0] op);
    case (op)
      OpcAdd, OpcAddi, OpcLw, OpcSw: return AluAdd;
      OpcSub:                        return AluSub;
      OpcAnd:                        return AluAnd;
      OpcOr:                         return AluOr;
      OpcXor:                        return AluXor;
      OpcSll:                        return AluSll;
      OpcSrl:                        return AluSrl;
      default:                       return AluZero;
    endcase
  endfunction

  function automatic logic op_uses_imm(input logic [3:0] op);
    return (op == OpcAddi) || (op == OpcLw) || (op == OpcSw);
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op >= OpcAdd) && (op <= OpcLw);
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// Register file: two asynchronous read ports with write-through, one synchronous write port,
// r0 hard-wired to zero, synchronous active-low clear.
module risc_regfile #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  localparam int unsigned NumRegs = 2 ** AW;

  logic [DW-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A read of the register being written this cycle sees the incoming value.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/risc_pipeline.sv
// Five-stage in-order 32-bit RISC datapath (IF/ID/EXE/MEM/WB) with externally supplied PC,
// internal instruction ROM and data RAM; every pipeline register is visible on a port.
module risc_pipeline
  import risc_pkg::*;
#(
  parameter int unsigned RFW     = 5,
  parameter int unsigned IMW     = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned IW      = 32,
  parameter int unsigned DMW     = 4,
  parameter string       IM_INIT = "im.hex"
) (
  input  logic           clk,
  input  logic           rf_reset,
  input  logic [IMW-1:0] pc_in,
  input  logic           im_cs,
  input  logic           rf_we_e,
  output logic [IMW-1:0] pc_out,
  output logic [IW-1:0]  if_id_out,
  output logic [DW-1:0]  id_exe_r1,
  output logic [DW-1:0]  id_exe_r2,
  output logic [DW-1:0]  exe_mem_out,
  output logic [DW-1:0]  mem_wb_out
);

  logic [IW-1:0] im [2**IMW];
  logic [DW-1:0] dm [2**DMW];

  // IF stage
  logic [IMW-1:0] pc_q;
  logic [IW-1:0]  if_id_q;

  always_ff @(posedge clk) begin
    if (!rf_reset) begin
      pc_q    <= '0;
      if_id_q <= '0;
    end else begin
      pc_q    <= pc_in;
      if_id_q <= im_cs ? im[pc_q] : '0;
    end
  end

  // ID stage
  logic [RFW-1:0] rs1_addr, rs2_addr;
  logic [DW-1:0]  rs1_data, rs2_data, imm_ext;
  logic [DW-1:0]  r1_q, r2_q, imm_ex_q;
  logic [3:0]     op_ex_q;
  logic [RFW-1:0] rd_ex_q;

  assign rs1_addr = if_id_q[Rs1Msb:Rs1Lsb];
  assign rs2_addr = if_id_q[Rs2Msb:Rs2Lsb];
  assign imm_ext  = {{(DW-ImmW){if_id_q[ImmMsb]}}, if_id_q[ImmMsb:0]};

  always_ff @(posedge clk) begin
    if (!rf_reset) begin
      r1_q     <= '0;
      r2_q     <= '0;
      imm_ex_q <= '0;
      op_ex_q  <= OpcNop;
      rd_ex_q  <= '0;
    end else begin
      r1_q     <= rs1_data;
      r2_q     <= rs2_data;
      imm_ex_q <= imm_ext;
      op_ex_q  <= if_id_q[OpMsb:OpLsb];
      rd_ex_q  <= if_id_q[RdMsb:RdLsb];
    end
  end

  // EXE stage
  logic [DW-1:0]  alu_b, alu_res;
  logic [DW-1:0]  exe_q, st_q;
  logic [3:0]     op_mem_q;
  logic [RFW-1:0] rd_mem_q;

  assign alu_b = op_uses_imm(op_ex_q) ? imm_ex_q : r2_q;

  always_comb begin
    alu_res = '0;
    unique case (alu_decode(op_ex_q))
      AluZero: alu_res = '0;
      AluAdd:  alu_res = r1_q + alu_b;
      AluSub:  alu_res = r1_q - alu_b;
      AluAnd:  alu_res = r1_q & alu_b;
      AluOr:   alu_res = r1_q | alu_b;
      AluXor:  alu_res = r1_q ^ alu_b;
      AluSll:  alu_res = r1_q << alu_b[4:0];
      AluSrl:  alu_res = r1_q >> alu_b[4:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rf_reset) begin
      exe_q    <= '0;
      st_q     <= '0;
      op_mem_q <= OpcNop;
      rd_mem_q <= '0;
    end else begin
      exe_q    <= alu_res;
      st_q     <= r2_q;
      op_mem_q <= op_ex_q;
      rd_mem_q <= rd_ex_q;
    end
  end

  // MEM stage: address wraps to the low DMW bits; memory contents survive reset
  logic [DMW-1:0] dm_addr;
  logic [DW-1:0]  wb_q;
  logic [3:0]     op_wb_q;
  logic [RFW-1:0] rd_wb_q;

  assign dm_addr = exe_q[DMW-1:0];

  always_ff @(posedge clk) begin
    if (rf_reset && (op_mem_q == OpcSw)) begin
      dm[dm_addr] <= st_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rf_reset) begin
      wb_q    <= '0;
      op_wb_q <= OpcNop;
      rd_wb_q <= '0;
    end else begin
      wb_q    <= (op_mem_q == OpcLw) ? dm[dm_addr] : exe_q;
      op_wb_q <= op_mem_q;
      rd_wb_q <= rd_mem_q;
    end
  end

  // WB stage
  logic rf_we;

  assign rf_we = rf_we_e && op_writes_rd(op_wb_q) && (rd_wb_q != '0);

  risc_regfile #(
    .AW (RFW),
    .DW (DW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rf_reset),
    .raddr_a_i (rs1_addr),
    .raddr_b_i (rs2_addr),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data),
    .we_i      (rf_we),
    .waddr_i   (rd_wb_q),
    .wdata_i   (wb_q)
  );

  assign pc_out      = pc_q;
  assign if_id_out   = if_id_q;
  assign id_exe_r1   = r1_q;
  assign id_exe_r2   = r2_q;
  assign exe_mem_out = exe_q;
  assign mem_wb_out  = wb_q;

endmodule

// File: tb/tb_risc_pipeline.sv
// Scoreboard bench for risc_pipeline: issue tasks queue per-stage expectations keyed by edge
// number; a negedge monitor pops and compares those that fall due.
module tb_risc_pipeline;

  logic        clk = 1'b0;
  logic        rf_reset;
  logic [3:0]  pc_in;
  logic        im_cs;
  logic        rf_we_e;
  logic [3:0]  pc_out;
  logic [31:0] if_id_out, id_exe_r1, id_exe_r2, exe_mem_out, mem_wb_out;

  always #5 clk = ~clk;

  risc_pipeline #(
    .IM_INIT ("")
  ) dut (
    .clk         (clk),
    .rf_reset    (rf_reset),
    .pc_in       (pc_in),
    .im_cs       (im_cs),
    .rf_we_e     (rf_we_e),
    .pc_out      (pc_out),
    .if_id_out   (if_id_out),
    .id_exe_r1   (id_exe_r1),
    .id_exe_r2   (id_exe_r2),
    .exe_mem_out (exe_mem_out),
    .mem_wb_out  (mem_wb_out)
  );

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          ecnt   = 0;
  logic [31:0] prog [16];

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      0:       return {28'd0, pc_out};
      1:       return if_id_out;
      2:       return id_exe_r1;
      3:       return id_exe_r2;
      4:       return exe_mem_out;
      default: return mem_wb_out;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      0:       return "pc_out";
      1:       return "if_id_out";
      2:       return "id_exe_r1";
      3:       return "id_exe_r2";
      4:       return "exe_mem_out";
      default: return "mem_wb_out";
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [12:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic void push(input int due, input int sig, input logic [31:0] val);
    exp_t e;
    e.due = due;
    e.sig = sig;
    e.val = val;
    sbq.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == ecnt) begin
        checks++;
        if (actual(sbq[i].sig) !== sbq[i].val) begin
          errors++;
          $display("FAIL %s @edge %0d: got %h want %h", sig_name(sbq[i].sig), ecnt,
                   actual(sbq[i].sig), sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present IM[idx] for one cycle then NOPs; expectations for every stage of that instruction.
  task automatic issue(input int idx, input int slot, input logic [31:0] e_r1,
                       input logic [31:0] e_r2, input logic [31:0] e_exe,
                       input logic [31:0] e_wb);
    int e;
    e = ecnt;
    push(e + 1, 0, 32'(idx));
    push(e + 2, 1, prog[idx]);
    push(e + 3, 2, e_r1);
    push(e + 3, 3, e_r2);
    push(e + 4, 4, e_exe);
    push(e + 5, 5, e_wb);
    pc_in = idx[3:0];
    step(1);
    pc_in = 4'd0;
    step(slot - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    prog[0]  = 32'h0;
    prog[1]  = enc(4'd8,  5'd1,  5'd0, 5'd0, 13'd5);      // ADDI r1,r0,5
    prog[2]  = enc(4'd1,  5'd3,  5'd1, 5'd1, 13'd0);      // ADD  r3,r1,r1
    prog[3]  = enc(4'd8,  5'd1,  5'd0, 5'd0, 13'h0FFF);   // ADDI r1,r0,0xFFF
    prog[4]  = enc(4'd8,  5'd1,  5'd1, 5'd0, 13'h0235);   // ADDI r1,r1,0x235 -> 0x1234
    prog[5]  = enc(4'd10, 5'd0,  5'd0, 5'd1, 13'd3);      // SW   r1 -> DM[r0+3]
    prog[6]  = enc(4'd9,  5'd4,  5'd0, 5'd0, 13'd3);      // LW   r4 <- DM[r0+3]
    prog[7]  = enc(4'd1,  5'd5,  5'd4, 5'd0, 13'd0);      // ADD  r5,r4,r0
    prog[8]  = enc(4'd10, 5'd0,  5'd0, 5'd3, 13'd19);     // SW   r3 -> DM[19] aliases DM[3]
    prog[9]  = enc(4'd8,  5'd2,  5'd0, 5'd0, 13'd1);      // ADDI r2,r0,1
    prog[10] = enc(4'd2,  5'd6,  5'd0, 5'd2, 13'd0);      // SUB  r6,r0,r2
    prog[11] = enc(4'd8,  5'd8,  5'd0, 5'd0, 13'd31);     // ADDI r8,r0,31
    prog[12] = enc(4'd6,  5'd7,  5'd2, 5'd8, 13'd0);      // SLL  r7,r2,r8
    prog[13] = enc(4'd7,  5'd9,  5'd7, 5'd8, 13'd0);      // SRL  r9,r7,r8
    prog[14] = enc(4'd8,  5'd10, 5'd1, 5'd0, 13'h1FFF);   // ADDI r10,r1,-1
    prog[15] = enc(4'd1,  5'd0,  5'd1, 5'd1, 13'd0);      // ADD  r0,r1,r1
    for (int i = 0; i < 16; i++) dut.im[i] = prog[i];

    rf_reset = 1'b0;
    pc_in    = 4'd5;
    im_cs    = 1'b1;
    rf_we_e  = 1'b1;
    step(3);
    for (int s = 0; s < 6; s++) push(ecnt, s, 32'h0);
    rf_reset = 1'b1;
    pc_in    = 4'd0;
    step(1);

    issue(1,  5, 32'h0,        32'h0,    32'h5,        32'h5);
    issue(2,  5, 32'h5,        32'h5,    32'hA,        32'hA);
    issue(3,  5, 32'h0,        32'h0,    32'hFFF,      32'hFFF);
    issue(4,  5, 32'hFFF,      32'h0,    32'h1234,     32'h1234);
    issue(5,  5, 32'h0,        32'h1234, 32'h3,        32'h3);
    issue(6,  5, 32'h0,        32'h0,    32'h3,        32'h1234);
    issue(7,  5, 32'h1234,     32'h0,    32'h1234,     32'h1234);
    issue(8,  5, 32'h0,        32'hA,    32'd19,       32'd19);
    issue(6,  5, 32'h0,        32'h0,    32'h3,        32'hA);
    issue(9,  3, 32'h0,        32'h0,    32'h1,        32'h1);
    issue(10, 5, 32'h0,        32'h1,    32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(11, 5, 32'h0,        32'h0,    32'd31,       32'd31);
    issue(12, 5, 32'h1,        32'd31,   32'h80000000, 32'h80000000);
    issue(13, 5, 32'h80000000, 32'd31,   32'h1,        32'h1);
    issue(14, 5, 32'h1234,     32'h0,    32'h1233,     32'h1233);
    issue(15, 5, 32'h1234,     32'h1234, 32'h2468,     32'h2468);
    issue(5,  5, 32'h0,        32'h1234, 32'h3,        32'h3);

    // Reset while ADDI r1 sits in ID/EXE
    pc_in = 4'd1;
    step(1);
    pc_in = 4'd0;
    step(2);
    rf_reset = 1'b0;
    step(1);
    for (int s = 0; s < 6; s++) push(ecnt, s, 32'h0);
    rf_reset = 1'b1;
    step(1);

    issue(2,  5, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(13, 5, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(7,  5, 32'h0, 32'h0, 32'h0, 32'h0);

    e = ecnt;
    push(e + 1, 0, 32'h1);
    push(e + 2, 1, 32'h0);
    pc_in = 4'd1;
    im_cs = 1'b0;
    step(1);
    pc_in = 4'd0;
    step(1);
    im_cs = 1'b1;
    step(4);

    rf_we_e = 1'b0;
    issue(1, 5, 32'h0, 32'h0, 32'h5, 32'h5);
    issue(2, 5, 32'h0, 32'h0, 32'h0, 32'h0);
    rf_we_e = 1'b1;

    step(8);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
